ysyx_22051086_ifu: RTL and testbench

YSYX_22051086_IFU -- requirements
Module: ysyx_22051086_ifu

---
 rtl/ysyx_22051086_ifu.sv | 129 ++++++++++++
 tb/tb_ysyx_22051086_ifu.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22051086_ifu.sv
// Instruction fetch unit.
// Issues one fetch request at a time, buffers the returned instruction and
// hands it to decode with a valid/allowin handshake. Branch and exception
// redirects replace the PC at any point. A response that belongs to a
// wrong-path request is dropped.
//
// Ports
//   clk, rst                 clock; asynchronous active-low reset
//   inst_req_valid/ready     fetch request handshake
//   inst_addr[63:0]          fetch address (the current PC)
//   inst_resp_valid/data     fetch response; always accepted
//   br_bus[65:0]             {br_stall, br_taken, br_target[63:0]}
//   excp_bus[64:0]           {excp_valid, excp_target[63:0]}
//   id_allowin               decode can take an instruction
//   if_to_id_valid/bus[95:0] {pc, inst} towards decode
//
// state  | meaning
// S_REQ  | request for pc is presented to memory
// S_WAIT | request accepted, waiting for its response
// S_HOLD | instruction buffered, offered to decode

module ysyx_22051086_ifu #(
   parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        inst_req_valid,
   input  logic        inst_req_ready,
   output logic [63:0] inst_addr,
   input  logic        inst_resp_valid,
   input  logic [31:0] inst_resp_data,
   input  logic [65:0] br_bus,
   input  logic [64:0] excp_bus,
   input  logic        id_allowin,
   output logic        if_to_id_valid,
   output logic [95:0] if_to_id_bus
);

   localparam logic [1:0] S_REQ  = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_HOLD = 2'd2;

   logic [1:0]  state, state_nxt;
   logic [63:0] pc, pc_nxt;
   logic        discard, discard_nxt;
   logic [31:0] inst_buf, inst_buf_nxt;

   logic        br_stall, br_taken, excp_valid;
   logic [63:0] br_target, excp_target;
   logic        redirect;
   logic [63:0] redirect_target;

   assign {br_stall, br_taken, br_target} = br_bus;
   assign {excp_valid, excp_target}       = excp_bus;

   // Exception redirects win over branches.
   assign redirect        = excp_valid || (br_taken && !br_stall);
   assign redirect_target = excp_valid ? excp_target : br_target;

   // rst gates the request so nothing is issued while reset is held.
   assign inst_req_valid = rst && (state == S_REQ);
   assign inst_addr      = pc;
   assign if_to_id_valid = (state == S_HOLD) && !redirect;
   assign if_to_id_bus   = {pc, inst_buf};

   always_comb begin
      state_nxt    = state;
      pc_nxt       = pc;
      discard_nxt  = discard;
      inst_buf_nxt = inst_buf;
      case (state)
         S_REQ: begin
            if (redirect) begin
               pc_nxt = redirect_target;
            end
            if (inst_req_ready) begin
               state_nxt = S_WAIT;
               // The accepted request was for the old pc; its response is stale.
               if (redirect) begin
                  discard_nxt = 1'b1;
               end
            end
         end
         S_WAIT: begin
            if (redirect) begin
               pc_nxt = redirect_target;
            end
            if (inst_resp_valid) begin
               if (discard || redirect) begin
                  discard_nxt = 1'b0;
                  state_nxt   = S_REQ;
               end else begin
                  inst_buf_nxt = inst_resp_data;
                  state_nxt    = S_HOLD;
               end
            end else if (redirect) begin
               discard_nxt = 1'b1;
            end
         end
         S_HOLD: begin
            if (redirect) begin
               pc_nxt    = redirect_target;
               state_nxt = S_REQ;
            end else if (id_allowin) begin
               pc_nxt    = pc + 64'd4;
               state_nxt = S_REQ;
            end
         end
         default: begin
            state_nxt = S_REQ;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= S_REQ;
         pc       <= RESET_PC;
         discard  <= 1'b0;
         inst_buf <= 32'd0;
      end else begin
         state    <= state_nxt;
         pc       <= pc_nxt;
         discard  <= discard_nxt;
         inst_buf <= inst_buf_nxt;
      end
   end

endmodule

// File: tb/tb_ysyx_22051086_ifu.sv
module tb_ysyx_22051086_ifu;

   localparam logic [63:0] B = 64'h8000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        inst_req_valid;
   logic        inst_req_ready = 1'b0;
   logic [63:0] inst_addr;
   logic        inst_resp_valid = 1'b0;
   logic [31:0] inst_resp_data = 32'd0;
   logic [65:0] br_bus = 66'd0;
   logic [64:0] excp_bus = 65'd0;
   logic        id_allowin = 1'b0;
   logic        if_to_id_valid;
   logic [95:0] if_to_id_bus;

   ysyx_22051086_ifu #(.RESET_PC(B)) dut (
      .clk(clk), .rst(rst),
      .inst_req_valid(inst_req_valid), .inst_req_ready(inst_req_ready),
      .inst_addr(inst_addr),
      .inst_resp_valid(inst_resp_valid), .inst_resp_data(inst_resp_data),
      .br_bus(br_bus), .excp_bus(excp_bus), .id_allowin(id_allowin),
      .if_to_id_valid(if_to_id_valid), .if_to_id_bus(if_to_id_bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        ready;
      logic        rv;
      logic [31:0] rdata;
      logic        stall;
      logic        taken;
      logic [63:0] btgt;
      logic        ev;
      logic [63:0] etgt;
      logic        allow;
      logic        exp_req;
      logic [63:0] exp_addr;
      logic        exp_idv;
      logic [95:0] exp_bus;
   } vec_t;

   vec_t vecs[$];
   logic [95:0] sb_q[$];
   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic v(input logic ready, rv, input logic [31:0] rdata,
                    input logic stall, taken, input logic [63:0] btgt,
                    input logic ev, input logic [63:0] etgt, input logic allow,
                    input logic exp_req, input logic [63:0] exp_addr,
                    input logic exp_idv, input logic [95:0] exp_bus);
      vec_t t;
      t.ready = ready; t.rv = rv; t.rdata = rdata; t.stall = stall; t.taken = taken;
      t.btgt = btgt; t.ev = ev; t.etgt = etgt; t.allow = allow;
      t.exp_req = exp_req; t.exp_addr = exp_addr; t.exp_idv = exp_idv; t.exp_bus = exp_bus;
      vecs.push_back(t);
   endtask

   function automatic logic [31:0] mem_f(input logic [63:0] a);
      return a[31:0] ^ 32'h5A5A_0013;
   endfunction

   // Whole-bench time limit.
   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      logic        pend;
      int          cnt;
      logic [63:0] exp_pc;
      logic [63:0] paddr;
      int          pops;

      // ready, rv, rdata, stall, taken, btgt, ev, etgt, allow | req, addr, idv, bus
      v(1,0,32'h0,       0,0,64'h0,    0,64'h0,    0, 1,B,      0,96'h0);
      v(0,1,32'h13,      0,0,64'h0,    0,64'h0,    0, 0,B,      0,96'h0);
      for (int i = 0; i < 5; i++)
         v(0,0,32'h0,    0,0,64'h0,    0,64'h0,    0, 0,B,      1,{B,32'h13});
      v(0,0,32'h0,       0,0,64'h0,    0,64'h0,    1, 0,B,      1,{B,32'h13});
      v(0,0,32'h0,       0,0,64'h0,    0,64'h0,    0, 1,B+4,    0,96'h0);
      v(1,0,32'h0,       0,0,64'h0,    0,64'h0,    0, 1,B+4,    0,96'h0);
      v(0,0,32'h0,       0,1,B+'h100,  0,64'h0,    0, 0,B+4,    0,96'h0);
      v(0,1,32'h11111111,0,0,64'h0,    0,64'h0,    0, 0,B+'h100,0,96'h0);
      v(1,0,32'h0,       0,0,64'h0,    0,64'h0,    0, 1,B+'h100,0,96'h0);
      v(0,1,32'h22222222,0,0,64'h0,    0,64'h0,    0, 0,B+'h100,0,96'h0);
      v(0,0,32'h0,       0,1,B+'h300,  0,64'h0,    1, 0,B+'h100,0,96'h0);
      v(1,0,32'h0,       0,0,64'h0,    0,64'h0,    0, 1,B+'h300,0,96'h0);
      v(0,1,32'h33333333,0,0,64'h0,    0,64'h0,    0, 0,B+'h300,0,96'h0);
      v(0,0,32'h0,       0,1,B+'h300,  1,B+'h200,  0, 0,B+'h300,0,96'h0);
      v(0,0,32'h0,       0,0,64'h0,    0,64'h0,    0, 1,B+'h200,0,96'h0);
      v(1,0,32'h0,       1,1,B+'h400,  0,64'h0,    0, 1,B+'h200,0,96'h0);
      v(0,1,32'h44444444,0,0,64'h0,    0,64'h0,    0, 0,B+'h200,0,96'h0);
      v(0,0,32'h0,       0,0,64'h0,    0,64'h0,    1, 0,B+'h200,1,{B+64'h200,32'h44444444});
      v(1,0,32'h0,       0,1,B+'h500,  0,64'h0,    0, 1,B+'h204,0,96'h0);
      v(0,1,32'h55555555,0,0,64'h0,    0,64'h0,    0, 0,B+'h500,0,96'h0);
      v(0,0,32'h0,       0,1,B+'h600,  0,64'h0,    0, 1,B+'h500,0,96'h0);
      v(0,0,32'h0,       0,1,B+'h600,  0,64'h0,    0, 1,B+'h600,0,96'h0);
      v(1,0,32'h0,       0,0,64'h0,    0,64'h0,    0, 1,B+'h600,0,96'h0);
      v(0,1,32'h66666666,0,0,64'h0,    0,64'h0,    0, 0,B+'h600,0,96'h0);
      v(0,0,32'h0,       0,0,64'h0,    0,64'h0,    1, 0,B+'h600,1,{B+64'h600,32'h66666666});
      v(0,0,32'h0,       0,0,64'h0,    0,64'h0,    0, 1,B+'h604,0,96'h0);

      // Reset held.
      repeat (3) @(posedge clk);
      #1; #3;
      chk("rst_req_valid", {95'd0, inst_req_valid}, 96'd0);
      chk("rst_id_valid",  {95'd0, if_to_id_valid}, 96'd0);
      chk("rst_addr",      {32'd0, inst_addr}, {32'd0, B});
      chk("rst_bus",       if_to_id_bus, {B, 32'd0});
      @(posedge clk); #1;
      rst = 1'b1;

      foreach (vecs[i]) begin
         inst_req_ready  = vecs[i].ready;
         inst_resp_valid = vecs[i].rv;
         inst_resp_data  = vecs[i].rdata;
         br_bus          = {vecs[i].stall, vecs[i].taken, vecs[i].btgt};
         excp_bus        = {vecs[i].ev, vecs[i].etgt};
         id_allowin      = vecs[i].allow;
         #3;
         chk($sformatf("v%0d_req_valid", i), {95'd0, inst_req_valid}, {95'd0, vecs[i].exp_req});
         chk($sformatf("v%0d_addr", i), {32'd0, inst_addr}, {32'd0, vecs[i].exp_addr});
         chk($sformatf("v%0d_id_valid", i), {95'd0, if_to_id_valid}, {95'd0, vecs[i].exp_idv});
         if (vecs[i].exp_idv)
            chk($sformatf("v%0d_bus", i), if_to_id_bus, vecs[i].exp_bus);
         @(posedge clk); #1;
      end
      inst_req_ready = 0; inst_resp_valid = 0; br_bus = '0; excp_bus = '0; id_allowin = 0;

      // Reset pulse during WAIT, then a stale response after release.
      inst_req_ready = 1; #3;
      chk("wr_req_addr", {32'd0, inst_addr}, {32'd0, B + 64'h604});
      @(posedge clk); #1;
      inst_req_ready = 0; #2;
      rst = 1'b0; #1;
      chk("wr_rst_req_valid", {95'd0, inst_req_valid}, 96'd0);
      chk("wr_rst_addr", {32'd0, inst_addr}, {32'd0, B});
      @(posedge clk); #1;
      rst = 1'b1;
      inst_resp_valid = 1; inst_resp_data = 32'hDEADBEEF; #3;
      chk("wr_stale_req_valid", {95'd0, inst_req_valid}, 96'd1);
      chk("wr_stale_addr", {32'd0, inst_addr}, {32'd0, B});
      chk("wr_stale_id_valid", {95'd0, if_to_id_valid}, 96'd0);
      @(posedge clk); #1;
      inst_resp_valid = 0; #3;
      chk("wr_after_req_valid", {95'd0, inst_req_valid}, 96'd1);
      chk("wr_after_id_valid", {95'd0, if_to_id_valid}, 96'd0);
      inst_req_ready = 1;
      @(posedge clk); #1;
      inst_req_ready = 0; inst_resp_valid = 1; inst_resp_data = 32'h0050_0093;
      @(posedge clk); #1;
      inst_resp_valid = 0; id_allowin = 1; #3;
      chk("wr_fetch_id_valid", {95'd0, if_to_id_valid}, 96'd1);
      chk("wr_fetch_bus", if_to_id_bus, {B, 32'h0050_0093});
      @(posedge clk); #1;
      id_allowin = 0;

      // Redirect near the top of the address space, then a random stream
      // that wraps the PC.
      exp_pc = 64'hFFFF_FFFF_FFFF_FFF8;
      br_bus = {1'b0, 1'b1, exp_pc};
      @(posedge clk); #1;
      br_bus = '0;
      pend = 1'b0; cnt = 0; paddr = '0; pops = 0;
      for (int c = 0; c < 420; c++) begin
         inst_resp_valid = 1'b0;
         if (pend && cnt == 0) begin
            inst_resp_valid = 1'b1;
            inst_resp_data  = mem_f(paddr);
         end
         if (c >= 400) begin
            inst_req_ready = 1'b0;
            id_allowin     = 1'b1;
         end else begin
            inst_req_ready = !pend && ($urandom_range(0, 2) != 0);
            id_allowin     = ($urandom_range(0, 3) != 0);
         end
         #3;
         if (pend) begin
            if (cnt == 0) pend = 1'b0;
            else cnt--;
         end
         if (inst_req_valid && inst_req_ready) begin
            chk("sb_req_addr", {32'd0, inst_addr}, {32'd0, exp_pc});
            sb_q.push_back({exp_pc, mem_f(exp_pc)});
            paddr  = exp_pc;
            exp_pc = exp_pc + 64'd4;
            pend   = 1'b1;
            cnt    = $urandom_range(0, 2);
         end
         if (if_to_id_valid && id_allowin) begin
            if (sb_q.size() == 0) begin
               chk("sb_underflow", if_to_id_bus, 96'hx);
            end else begin
               chk("sb_bus", if_to_id_bus, sb_q.pop_front());
               pops++;
            end
         end
         @(posedge clk); #1;
      end
      chk("sb_drained", 96'(sb_q.size()), 96'd0);
      chk("sb_enough", {95'd0, pops >= 20}, 96'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
